// File: rtl/intersection_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : intersection_scheduler_if
// Description : Control/lamp bundle between the tick prescaler, the phase
//               scheduler and the lamp pin mux.
// Revision    : 1.0 - initial release
// ============================================================================
interface intersection_scheduler_if;
  logic       tick;     // one-clk timing enable
  logic       run;      // 1 = cycle, 0 = park at next clearance boundary
  logic       ped_req;  // pedestrian button
  logic [2:0] ns_rgy;   // NS lamp {R,Y,G}
  logic [2:0] ew_rgy;   // EW lamp {R,Y,G}
  logic       walk;     // walk lamp
  logic       ped_ack;  // one-clk grant pulse
  logic [2:0] phase;    // debug state code

  // Controller side: drives timing/run/button, observes lamps
  modport master (
    output tick, run, ped_req,
    input  ns_rgy, ew_rgy, walk, ped_ack, phase
  );

  // Scheduler side
  modport slave (
    input  tick, run, ped_req,
    output ns_rgy, ew_rgy, walk, ped_ack, phase
  );
endinterface
`default_nettype wire

// File: rtl/intersection_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : intersection_scheduler
// Description : Tick-driven phase sequencer for a two-way intersection with
//               one pedestrian crosswalk shared by both vehicle directions.
// Revision    : 1.0 - initial release
// ============================================================================
module intersection_scheduler #(
  parameter int CW          = 6,
  parameter int T_GREEN     = 20,
  parameter int T_MIN_GREEN = 5,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 1,
  parameter int T_WALK      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  intersection_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_ALLRED = 3'd3,
    S_WALK   = 3'd4
  } state_t;

  // Last count value of each phase: a phase of length T exits at cnt == T-1
  localparam logic [CW-1:0] c_green_last     = CW'(T_GREEN - 1);
  localparam logic [CW-1:0] c_min_green_last = CW'(T_MIN_GREEN - 1);
  localparam logic [CW-1:0] c_yellow_last    = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] c_allred_last    = CW'(T_ALLRED - 1);
  localparam logic [CW-1:0] c_walk_last      = CW'(T_WALK - 1);

  state_t          r_state;
  logic            r_dir;    // 0 = NS owns green/yellow, 1 = EW
  logic [CW-1:0]   r_cnt;
  logic            r_pend;   // latched pedestrian request
  logic            r_ack;

  logic            w_green_exit;
  logic            w_clear_exit;
  logic [2:0]      w_ns_rgy;
  logic [2:0]      w_ew_rgy;

  // Green ends at full length, or early once a request is waiting and the
  // minimum green has been served
  assign w_green_exit = (r_cnt == c_green_last) ||
                        (r_pend && (r_cnt >= c_min_green_last));

  // ALLRED and WALK are the two clearance phases that hand over direction
  assign w_clear_exit = (r_state == S_WALK) ? (r_cnt == c_walk_last)
                                            : (r_cnt == c_allred_last);

  // Phase sequencer: state, direction, phase counter, request latch and grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (bus.ped_req) begin
        r_pend <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.tick) begin
            if (bus.run) begin
              r_state <= S_GREEN;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_GREEN: begin
          if (bus.tick) begin
            if (w_green_exit) begin
              r_state <= S_YELLOW;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_YELLOW: begin
          if (bus.tick) begin
            if (r_cnt == c_yellow_last) begin
              r_cnt <= '0;
              if (r_pend) begin
                // Entering WALK consumes the request; this clear overrides
                // a button press on the same edge
                r_state <= S_WALK;
                r_pend  <= 1'b0;
                r_ack   <= 1'b1;
              end else begin
                r_state <= S_ALLRED;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_ALLRED, S_WALK: begin
          if (bus.tick) begin
            if (w_clear_exit) begin
              r_dir   <= ~r_dir;
              r_cnt   <= '0;
              r_state <= bus.run ? S_GREEN : S_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Lamp decode straight from registered state; only the owning direction
  // can ever leave red, so the two heads are mutually exclusive
  always_comb begin
    w_ns_rgy = 3'b100;
    w_ew_rgy = 3'b100;
    if (r_state == S_GREEN) begin
      if (r_dir) w_ew_rgy = 3'b001;
      else       w_ns_rgy = 3'b001;
    end else if (r_state == S_YELLOW) begin
      if (r_dir) w_ew_rgy = 3'b010;
      else       w_ns_rgy = 3'b010;
    end
  end

  assign bus.ns_rgy  = w_ns_rgy;
  assign bus.ew_rgy  = w_ew_rgy;
  assign bus.walk    = (r_state == S_WALK);
  assign bus.ped_ack = r_ack;
  assign bus.phase   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_intersection_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_intersection_scheduler
// Description : Scoreboard bench for intersection_scheduler; a reference
//               model pushes the expected lamp/phase word after every edge,
//               and it is popped and compared on the following falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intersection_scheduler;

  localparam int TG  = 20;
  localparam int TMG = 5;
  localparam int TY  = 3;
  localparam int TAR = 1;
  localparam int TW  = 8;

  logic clk;
  logic rst_n;

  intersection_scheduler_if bus ();
  intersection_scheduler_if b2 ();

  intersection_scheduler #(
    .CW(6), .T_GREEN(TG), .T_MIN_GREEN(TMG), .T_YELLOW(TY),
    .T_ALLRED(TAR), .T_WALK(TW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Second instance for the shortest legal green
  intersection_scheduler #(
    .CW(6), .T_GREEN(1), .T_MIN_GREEN(1), .T_YELLOW(TY),
    .T_ALLRED(TAR), .T_WALK(TW)
  ) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2)
  );

  int n_cmp = 0;
  int n_err = 0;
  int ack_cnt = 0;
  int tick_div = 4;
  int cyc = 0;

  logic [10:0] sb[$];
  logic [10:0] last_exp;

  // model state
  logic [2:0] m_state, nx_state;
  logic       m_dir, nx_dir, m_pend, nx_pend, nx_ack;
  int         m_cnt, nx_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] exp_vec(input logic [2:0] s, input logic d,
                                          input logic a);
    logic [2:0] ns, ew;
    ns = 3'b100;
    ew = 3'b100;
    if (s == 3'd1) begin
      if (d) ew = 3'b001; else ns = 3'b001;
    end
    if (s == 3'd2) begin
      if (d) ew = 3'b010; else ns = 3'b010;
    end
    return {s, ns, ew, (s == 3'd4), a};
  endfunction

  // Reference model, stepped on the same edge as the DUT
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 3'd0;
      m_dir   <= 1'b0;
      m_cnt   <= 0;
      m_pend  <= 1'b0;
      sb.delete();
      sb.push_back(exp_vec(3'd0, 1'b0, 1'b0));
    end else begin
      nx_state = m_state;
      nx_dir   = m_dir;
      nx_cnt   = m_cnt;
      nx_ack   = 1'b0;
      nx_pend  = m_pend | bus.ped_req;
      if (bus.tick) begin
        case (m_state)
          3'd0: if (bus.run) nx_state = 3'd1;
          3'd1: if (m_cnt == TG - 1 || (m_pend && m_cnt >= TMG - 1)) nx_state = 3'd2;
          3'd2: if (m_cnt == TY - 1) nx_state = m_pend ? 3'd4 : 3'd3;
          3'd3: if (m_cnt == TAR - 1) begin
                  nx_state = bus.run ? 3'd1 : 3'd0;
                  nx_dir   = ~m_dir;
                end
          3'd4: if (m_cnt == TW - 1) begin
                  nx_state = bus.run ? 3'd1 : 3'd0;
                  nx_dir   = ~m_dir;
                end
          default: nx_state = 3'd0;
        endcase
        nx_cnt = (nx_state != m_state) ? 0 : m_cnt + 1;
        if (nx_state == 3'd4 && m_state != 3'd4) begin
          nx_pend = 1'b0;
          nx_ack  = 1'b1;
        end
      end
      m_state <= nx_state;
      m_dir   <= nx_dir;
      m_cnt   <= nx_cnt;
      m_pend  <= nx_pend;
      sb.push_back(exp_vec(nx_state, nx_dir, nx_ack));
    end
  end

  // Scoreboard check on the falling edge
  always @(negedge clk) begin
    if (sb.size() > 0) last_exp = sb.pop_front();
    check_value("outs", {bus.phase, bus.ns_rgy, bus.ew_rgy, bus.walk, bus.ped_ack},
                last_exp);
    check_value("excl", (bus.ns_rgy != 3'b100) && (bus.ew_rgy != 3'b100), 0);
    if (bus.ped_ack) ack_cnt++;
  end

  // Prescaler stand-in
  initial begin
    bus.tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.tick = ((cyc % tick_div) == 0);
    end
  end

  task automatic wait_phase(input logic [2:0] p, input int budget);
    int g;
    g = 0;
    while (bus.phase != p && g < budget) begin
      @(negedge clk);
      g++;
    end
    check_value("wait_phase", (g < budget), 1);
  endtask

  // Ticks consumed while the current phase equals p; returns at the first
  // falling edge where the phase has moved on
  task automatic measure(input logic [2:0] p, output int n);
    int g;
    n = 0;
    g = 0;
    while (bus.phase == p && g < 4000) begin
      if (bus.tick) n++;
      @(negedge clk);
      g++;
    end
    check_value("measure_bound", (g < 4000), 1);
  endtask

  task automatic skip_ticks(input int k);
    logic t;
    while (k > 0) begin
      t = bus.tick;
      @(negedge clk);
      if (t) k--;
    end
  endtask

  task automatic pulse_ped();
    bus.ped_req = 1'b1;
    @(negedge clk);
    bus.ped_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    b2.tick    = 1'b1;
    b2.run     = 1'b1;
    b2.ped_req = 1'b0;
  end

  initial begin
    int n, sum, acks;
    last_exp    = exp_vec(3'd0, 1'b0, 1'b0);
    rst_n       = 1'b1;
    bus.run     = 1'b0;
    bus.ped_req = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Parked in IDLE while run=0, request-free
    repeat (20) @(negedge clk);
    check_value("idle_hold", bus.phase, 0);

    // Nominal cycle
    bus.run = 1'b1;
    wait_phase(3'd1, 40);
    check_value("ns_green_lamp", bus.ns_rgy, 3'b001);
    sum = 0;
    measure(3'd1, n); check_value("ns_green_len", n, TG); sum += n;
    check_value("ns_yellow_lamp", bus.ns_rgy, 3'b010);
    measure(3'd2, n); check_value("ns_yellow_len", n, TY); sum += n;
    check_value("allred_phase", bus.phase, 3);
    measure(3'd3, n); check_value("ns_allred_len", n, TAR); sum += n;
    check_value("ew_green_lamp", bus.ew_rgy, 3'b001);
    measure(3'd1, n); check_value("ew_green_len", n, TG); sum += n;
    measure(3'd2, n); check_value("ew_yellow_len", n, TY); sum += n;
    measure(3'd3, n); check_value("ew_allred_len", n, TAR); sum += n;
    check_value("period", sum, 48);

    // Early cut: request at NS green cnt=2
    check_value("ns_green_again", bus.ns_rgy, 3'b001);
    skip_ticks(2);
    pulse_ped();
    measure(3'd1, n); check_value("cut_green_rest", n, 3);
    measure(3'd2, n); check_value("cut_yellow_len", n, TY);
    check_value("cut_walk_phase", bus.phase, 4);
    acks = ack_cnt;
    measure(3'd4, n); check_value("walk_len", n, TW);
    check_value("walk_ack_once", ack_cnt - acks, 1);
    check_value("ew_after_walk", bus.ew_rgy, 3'b001);

    // Late request during EW yellow, then another during WALK
    measure(3'd1, n); check_value("ew_green_full", n, TG);
    skip_ticks(1);
    pulse_ped();
    measure(3'd2, n); check_value("late_yellow_rest", n, 2);
    check_value("late_walk_phase", bus.phase, 4);
    skip_ticks(3);
    pulse_ped();
    measure(3'd4, n); check_value("late_walk_rest", n, 5);
    check_value("ns_after_walk", bus.ns_rgy, 3'b001);
    acks = ack_cnt;
    measure(3'd1, n); check_value("ns_green_cut2", n, TMG);
    measure(3'd2, n);
    check_value("walk_again_phase", bus.phase, 4);
    measure(3'd4, n);
    check_value("walk_again_ack", ack_cnt - acks, 1);

    // Stop at EW green cnt=10
    check_value("ew_green_stop", bus.ew_rgy, 3'b001);
    skip_ticks(10);
    bus.run = 1'b0;
    measure(3'd1, n); check_value("stop_green_rest", n, TG - 10);
    measure(3'd2, n); check_value("stop_yellow_len", n, TY);
    measure(3'd3, n); check_value("stop_allred_len", n, TAR);
    check_value("stop_idle", bus.phase, 0);
    check_value("stop_lamps", {bus.ns_rgy, bus.ew_rgy}, 6'b100100);
    repeat (12) @(negedge clk);
    check_value("stop_idle_hold", bus.phase, 0);
    bus.run = 1'b1;
    wait_phase(3'd1, 10);
    check_value("restart_ns", bus.ns_rgy, 3'b001);

    // Reset mid-green with a pending request
    skip_ticks(3);
    pulse_ped();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_value("rst_phase", bus.phase, 0);
    check_value("rst_lamps", {bus.ns_rgy, bus.ew_rgy, bus.walk}, 7'b1001000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_phase(3'd1, 40);
    measure(3'd1, n); check_value("rst_drops_req", n, TG);

    // Stress: tick every clk, button pressed on the WALK entry edge
    tick_div = 1;
    wait_phase(3'd1, 200);
    pulse_ped();
    wait_phase(3'd2, 200);
    skip_ticks(TY - 1);
    pulse_ped();
    check_value("stress_walk", bus.phase, 4);
    measure(3'd4, n); check_value("stress_walk_len", n, TW);
    measure(3'd1, n); check_value("stress_no_relatch", n, TG);

    // Shortest green on the second instance
    n = 0;
    while (b2.phase != 3'd1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_value("min_green_found", (n < 100), 1);
    n = 0;
    while (b2.phase == 3'd1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_value("min_green_len", n, 1);
    check_value("min_green_next", b2.phase, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
